freq_bcd_conv: RTL
==================

Name: freq_bcd_conv

Overview:
- Downstream neighbour of the cymometer and feeds the LCD character stage.
- Takes each new 30-bit binary frequency result and converts it to 10 packed BCD digits using a sequential double-dabble engine (shift-and-add-3).
- Reports the count of significant digits so the LCD stage can blank leading zeros.
- A one-deep pending slot absorbs results that arrive while a conversion is still running.

Parameters:
- DATA_W, 30: binary input width (frequency in Hz).
- DIGITS, 10: BCD digits produced. Must satisfy 10^DIGITS > 2^DATA_W - 1.

Ports:
- sys_clk, input, 1: system clock (50 MHz).
- sys_rst, input, 1: reset.
- data_fx, input, DATA_W: binary frequency value.
- data_vld, input, 1: one-cycle strobe; data_fx is valid.
- busy, output, 1: conversion in progress.
- bcd, output, 4*DIGITS: packed BCD result, digit 0 in bits [3:0].
- num_dig, output, 4: significant digits in bcd (1..DIGITS).
- bcd_vld, output, 1: one-cycle strobe; bcd and num_dig updated.
- drop, output, 1: one-cycle strobe; an unconverted pending value was overwritten.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values (sys_rst sampled high at a sys_clk edge): state IDLE, busy=0, bcd=0, num_dig=1, bcd_vld=0, drop=0, pend_vld=0, shift register and counter cleared.
- States are IDLE, CONV and DONE. busy = (state != IDLE).
- IDLE:
  - If data_vld=1, load data_fx into the binary part of the shift register, clear the BCD part, clear the counter and go to CONV.
  - Else if pend_vld=1, load pend_data the same way, clear pend_vld and go to CONV.
  - data_vld has priority over pend_vld. If both are set, pend_data is discarded and drop pulses.
- CONV, each cycle:
  - Every BCD nibble >= 5 first gets +3 (all nibbles in parallel, combinational).
  - Then the whole register shifts left by 1.
  - Counter increments. After the DATA_W-th shift (cnt == DATA_W-1), go to DONE.
- DONE (one cycle):
  - Register the BCD part into bcd.
  - Compute num_dig = index of the highest non-zero nibble + 1, or 1 if all nibbles are zero. Register it.
  - Pulse bcd_vld=1 for exactly one cycle, then go to IDLE.
- Latency: data_vld accepted at edge N. Shifts occur at edges N+1..N+DATA_W. bcd, num_dig and bcd_vld update at edge N+DATA_W+1, i.e. 31 clocks for default parameters.
  - busy is high from edge N through edge N+DATA_W+1.
  - Minimum spacing between bcd_vld pulses is DATA_W+2 clocks.
- Pending slot:
  - data_vld while state != IDLE stores data_fx into pend_data and sets pend_vld.
  - If pend_vld was already 1, the old value is lost and drop pulses one cycle.
- bcd and num_dig hold their value between bcd_vld pulses. They are never partially updated.
- data_fx is sampled only on cycles with data_vld=1. Other values are ignored.
- Reset mid-conversion aborts with no bcd_vld, and the pending slot is cleared.
- No divide or multiply operators. The +3 adjust is a 4-bit compare-and-add per nibble.

Test Plan:
- data_fx=0, data_vld pulse -> after 31 clk: bcd=40'h0000000000, num_dig=1, bcd_vld high exactly 1 cycle, busy high 31 cycles.
- data_fx=12_345_678 -> bcd=40'h0012345678, num_dig=8. data_fx=50_000_000 -> bcd=40'h0050000000, num_dig=8.
- data_fx=30'h3FFFFFFF (1_073_741_823) -> bcd=40'h1073741823, num_dig=10. data_fx=9 -> bcd=...09, num_dig=1.
- data_vld(1000) at t0, data_vld(100) at t0+5, data_vld(200) at t0+10 -> drop pulse at t0+11. Expected bcd_vld sequence:
  - bcd=...1000, num_dig=4.
  - Then, starting 1 clk after return to IDLE, bcd=...0200, num_dig=3.
  - 100 is never output.
- sys_rst high at t0+15 during conversion of 777 -> next edge busy=0, bcd=0, num_dig=1, no bcd_vld. A following data_vld(42) yields bcd=...42, num_dig=2 after 31 clk.
- Random 500 values in 0..2^30-1 with random gaps -> every bcd_vld matches the reference decimal conversion. bcd_vld count + drop count = data_vld count minus any still pending.

Source files
------------

// File: rtl/freq_bcd_conv_if.sv
// Handshake bundle between the frequency producer, the BCD converter and the LCD stage.
interface freq_bcd_conv_if #(
    parameter int DATA_W = 30,
    parameter int DIGITS = 10
);
    logic [DATA_W-1:0]   data_fx;
    logic                data_vld;
    logic                busy;
    logic [4*DIGITS-1:0] bcd;
    logic [3:0]          num_dig;
    logic                bcd_vld;
    logic                drop;

    modport master (
        output data_fx, data_vld,
        input  busy, bcd, num_dig, bcd_vld, drop
    );

    modport slave (
        input  data_fx, data_vld,
        output busy, bcd, num_dig, bcd_vld, drop
    );
endinterface

// File: rtl/freq_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter with a one-deep pending slot
// and a significant-digit count for leading-zero blanking.
module freq_bcd_conv #(
    parameter int DATA_W = 30,
    parameter int DIGITS = 10
) (
    input logic            sys_clk,
    input logic            sys_rst,
    freq_bcd_conv_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t            state;
    logic [SR_W-1:0]   sreg;      // BCD digits above, binary value below
    logic [SR_W-1:0]   sreg_adj;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] pend_data;
    logic              pend_vld;
    logic [3:0]        sig_dig;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sreg_adj = sreg;
        for (int i = 0; i < DIGITS; i++) begin
            if (sreg[DATA_W + 4*i +: 4] >= 4'd5)
                sreg_adj[DATA_W + 4*i +: 4] = sreg[DATA_W + 4*i +: 4] + 4'd3;
        end
    end

    // Highest non-zero digit wins; an all-zero result still shows one digit.
    always_comb begin
        sig_dig = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (sreg[DATA_W + 4*i +: 4] != 4'd0)
                sig_dig = 4'(i + 1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.bcd     <= '0;
            bus.num_dig <= 4'd1;
            bus.bcd_vld <= 1'b0;
            bus.drop    <= 1'b0;
            pend_vld    <= 1'b0;
            pend_data   <= '0;
            sreg        <= '0;
            cnt         <= '0;
        end else begin
            bus.bcd_vld <= 1'b0;
            bus.drop    <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.data_vld) begin
                        sreg     <= {{BCD_W{1'b0}}, bus.data_fx};
                        cnt      <= '0;
                        state    <= CONV;
                        bus.busy <= 1'b1;
                        if (pend_vld) begin
                            pend_vld <= 1'b0;
                            bus.drop <= 1'b1;
                        end
                    end else if (pend_vld) begin
                        sreg     <= {{BCD_W{1'b0}}, pend_data};
                        cnt      <= '0;
                        pend_vld <= 1'b0;
                        state    <= CONV;
                        bus.busy <= 1'b1;
                    end
                end

                CONV: begin
                    sreg <= sreg_adj << 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1))
                        state <= DONE;
                end

                DONE: begin
                    bus.bcd     <= sreg[SR_W-1:DATA_W];
                    bus.num_dig <= sig_dig;
                    bus.bcd_vld <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase

            // Results arriving mid-conversion park here; a second one evicts the first.
            if (state != IDLE && bus.data_vld) begin
                pend_data <= bus.data_fx;
                pend_vld  <= 1'b1;
                if (pend_vld)
                    bus.drop <= 1'b1;
            end
        end
    end
endmodule
